tdc_meas_sched: RTL and testbench

//  Sequences one TDC start->stop measurement per second in the timing FPGA: fires TDC start on the top of second, times coarse clk_tf cycles to the stop, reads the TDC fine result over a req/ack port, and queues a tagged record for the uC.

---
 rtl/timing_pkg.sv | 25 ++
 rtl/tdc_result_fifo.sv | 46 ++++
 rtl/tdc_meas_sched.sv | 144 ++++++++++++++
 tb/tb_tdc_meas_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/timing_pkg.sv
// Shared types for the TDC measurement sequencer: FSM states,
// result record layout and flag bit positions.
package timing_pkg;

    localparam int COARSE_W  = 24;
    localparam int FINE_W    = 23;
    localparam int FLAG_TMO  = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_MISS = 2;

    typedef enum logic [1:0] {
        S_idle,
        S_armed,
        S_read,
        S_push
    } meas_state_t;

    typedef struct packed {
        logic [7:0]          seq;
        logic [2:0]          flags;
        logic [COARSE_W-1:0] coarse;
        logic [FINE_W-1:0]   fine;
    } meas_rec_t;

endpackage

// File: rtl/tdc_result_fifo.sv
// First-word-fall-through result queue; a pop in the same cycle
// frees room for a push even when full.
module tdc_result_fifo #(
    parameter int Width = 58,
    parameter int Depth = 4
) (
    input  logic             clk_tf,
    input  logic             tf_reset,
    input  logic             push,
    input  logic [Width-1:0] din,
    input  logic             pop,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = pop && !empty;
    assign do_wr = push && (!full || do_rd);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_tf or posedge tf_reset) begin
        if (tf_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_tf) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/tdc_meas_sched.sv
// Per-second TDC start/stop sequencer with tagged result queue.
// Define TDC_TIMEOUT_EN to abandon a measurement after MaxCoarse cycles.
module tdc_meas_sched
    import timing_pkg::*;
#(
    parameter int CoarseWidth = COARSE_W,
    parameter int FineWidth   = FINE_W,
    parameter int FifoDepth   = 4,
    parameter int MaxCoarse   = 96000
) (
    input  logic                                clk_tf,
    input  logic                                tf_reset,
    input  logic                                meas_en,
    input  logic                                tos_mark,
    input  logic                                tdc_stop_next,
    output logic                                tdc_start_next,
    output logic                                tdc_rd_req,
    input  logic                                tdc_rd_ack,
    input  logic [FineWidth-1:0]                tdc_rd_data,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [8+3+CoarseWidth+FineWidth-1:0] res_data,
    output logic                                busy
);

`ifdef TDC_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    localparam int RecW = 8 + 3 + CoarseWidth + FineWidth;

    meas_state_t            state, state_n;
    logic [CoarseWidth-1:0] coarse_cnt;
    logic [CoarseWidth-1:0] coarse_inc;
    logic [CoarseWidth-1:0] coarse_q;
    logic [FineWidth-1:0]   fine_q;
    logic [7:0]             seq;
    logic                   tmo_q;
    logic                   ovf_q;
    logic                   miss_q;
    logic [2:0]             flags;
    logic                   stop_hit;
    logic                   timeout;
    logic                   ack_hit;
    logic                   push;
    logic                   pop;
    logic                   push_ok;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign coarse_inc = (&coarse_cnt) ? coarse_cnt : coarse_cnt + 1'b1;
    assign stop_hit   = (state == S_armed) && tdc_stop_next;
    assign timeout    = TmoEn && (state == S_armed) &&
                        (coarse_cnt == CoarseWidth'(MaxCoarse - 1));
    assign ack_hit    = (state == S_read) && tdc_rd_ack;
    assign push       = (state == S_push);
    assign pop        = res_valid && res_ready;
    assign push_ok    = !fifo_full || pop;
    assign res_valid  = !fifo_empty;
    assign busy       = (state != S_idle);

    always_comb begin
        flags            = '0;
        flags[FLAG_TMO]  = tmo_q;
        flags[FLAG_OVF]  = ovf_q;
        flags[FLAG_MISS] = miss_q;
    end

    always_comb begin
        state_n        = state;
        tdc_start_next = 1'b0;
        unique case (state)
            S_idle: begin
                if (tos_mark && meas_en) begin
                    tdc_start_next = 1'b1;
                    state_n        = S_armed;
                end
            end
            S_armed: begin
                if (stop_hit)     state_n = S_read;
                else if (timeout) state_n = S_push;
            end
            S_read: begin
                if (ack_hit) state_n = S_push;
            end
            S_push:  state_n = S_idle;
            default: state_n = S_idle;
        endcase
    end

    always_ff @(posedge clk_tf or posedge tf_reset) begin
        if (tf_reset) begin
            state      <= S_idle;
            coarse_cnt <= '0;
            coarse_q   <= '0;
            fine_q     <= '0;
            seq        <= '0;
            tmo_q      <= 1'b0;
            ovf_q      <= 1'b0;
            miss_q     <= 1'b0;
            tdc_rd_req <= 1'b0;
        end else begin
            state      <= state_n;
            coarse_cnt <= (state == S_armed) ? coarse_inc : '0;
            if (stop_hit) begin
                coarse_q   <= coarse_inc;
                tmo_q      <= 1'b0;
                tdc_rd_req <= 1'b1;
            end else if (timeout) begin
                coarse_q <= CoarseWidth'(MaxCoarse);
                fine_q   <= '0;
                tmo_q    <= 1'b1;
            end
            if (ack_hit) begin
                fine_q     <= tdc_rd_data;
                tdc_rd_req <= 1'b0;
            end
            if (push) begin
                seq   <= seq + 8'd1;
                ovf_q <= !push_ok;
            end
            // a tos_mark seen during the push cycle belongs to the next record
            miss_q <= (miss_q && !(push && push_ok)) ||
                      (tos_mark && state != S_idle);
        end
    end

    tdc_result_fifo #(
        .Width (RecW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_tf   (clk_tf),
        .tf_reset (tf_reset),
        .push     (push),
        .din      ({seq, flags, coarse_q, fine_q}),
        .pop      (pop),
        .dout     (res_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_tdc_meas_sched.sv
// Directed scoreboard bench for tdc_meas_sched.
// Build with TDC_TIMEOUT_EN to cover the timeout record path.
module tb_tdc_meas_sched;
    import timing_pkg::*;

    localparam int MAXC = 50;

    logic        clk_tf = 1'b0;
    logic        tf_reset;
    logic        meas_en;
    logic        tos_mark;
    logic        tdc_stop_next;
    logic        tdc_start_next;
    logic        tdc_rd_req;
    logic        tdc_rd_ack;
    logic [22:0] tdc_rd_data;
    logic        res_valid;
    logic        res_ready;
    logic [57:0] res_data;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int seq_e = 0;
    meas_rec_t sb[$];

    always #5 clk_tf = ~clk_tf;

    tdc_meas_sched #(.MaxCoarse(MAXC)) dut (
        .clk_tf         (clk_tf),
        .tf_reset       (tf_reset),
        .meas_en        (meas_en),
        .tos_mark       (tos_mark),
        .tdc_stop_next  (tdc_stop_next),
        .tdc_start_next (tdc_start_next),
        .tdc_rd_req     (tdc_rd_req),
        .tdc_rd_ack     (tdc_rd_ack),
        .tdc_rd_data    (tdc_rd_data),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .busy           (busy)
    );

    task automatic tick();
        @(posedge clk_tf);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        tf_reset = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_req", tdc_rd_req, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        tf_reset = 1'b0;
        sb.delete();
        seq_e = 0;
    endtask

    task automatic meas(input int s, input int a, input logic [22:0] f,
                        input logic [2:0] fl, input bit keep,
                        input bit tos_rd, input bit pop_push);
        meas_rec_t r;
        tos_mark = 1'b1;
        meas_en  = 1'b1;
        #1;
        chk("start", tdc_start_next, 1);
        tick();
        tos_mark = 1'b0;
        repeat (s - 1) tick();
        tdc_stop_next = 1'b1;
        tick();
        tdc_stop_next = 1'b0;
        chk("req_on", tdc_rd_req, 1);
        repeat (a) tick();
        tdc_rd_ack  = 1'b1;
        tdc_rd_data = f;
        if (tos_rd) begin
            tos_mark = 1'b1;
            #1;
            chk("no_start", tdc_start_next, 0);
        end
        tick();
        tdc_rd_ack  = 1'b0;
        tdc_rd_data = '0;
        tos_mark    = 1'b0;
        chk("req_off", tdc_rd_req, 0);
        chk("busy_push", busy, 1);
        if (pop_push) begin
            chk("head_pop", res_data, sb.pop_front());
            res_ready = 1'b1;
        end
        r.seq    = seq_e[7:0];
        r.flags  = fl;
        r.coarse = 24'(s);
        r.fine   = f;
        tick();
        res_ready = 1'b0;
        if (keep) sb.push_back(r);
        seq_e++;
    endtask

    task automatic drain();
        int k;
        res_ready = 1'b1;
        while (sb.size() > 0) begin
            k = 0;
            while (!res_valid && k < 20) begin
                tick();
                k++;
            end
            chk("res_valid", res_valid, 1);
            chk("res_data", res_data, sb.pop_front());
            tick();
        end
        res_ready = 1'b0;
        chk("drained", res_valid, 0);
    endtask

    initial begin
        bit saw;
        meas_rec_t r;
        tf_reset      = 1'b1;
        meas_en       = 1'b0;
        tos_mark      = 1'b0;
        tdc_stop_next = 1'b0;
        tdc_rd_ack    = 1'b0;
        tdc_rd_data   = '0;
        res_ready     = 1'b0;
        #2;
        do_reset();

        // basic measurement
        meas(3, 2, 23'h1234, 3'b000, 1, 0, 0);
        drain();

        // queue overflow: 4 kept, 5th dropped, next flagged
        do_reset();
        for (int i = 0; i < 4; i++)
            meas(2 + i, 1, 23'(16 + i), 3'b000, 1, 0, 0);
        meas(5, 1, 23'h7, 3'b000, 0, 0, 0);
        chk("full_valid", res_valid, 1);
        drain();
        meas(4, 1, 23'h55, 3'b010, 1, 0, 0);
        drain();

        // pop and push in the same cycle while full
        for (int i = 0; i < 4; i++)
            meas(1 + i, 0, 23'(32 + i), 3'b000, 1, 0, 0);
        meas(7, 3, 23'h7abcd, 3'b000, 1, 0, 1);
        drain();

        // tos_mark while busy
        meas(3, 1, 23'h111, 3'b100, 1, 1, 0);
        meas(2, 1, 23'h222, 3'b000, 1, 0, 0);
        drain();

        // no stop
        tos_mark = 1'b1;
        meas_en  = 1'b1;
        tick();
        tos_mark = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < MAXC + 10; i++) begin
            if (tdc_rd_req) saw = 1'b1;
            tick();
        end
        chk("tmo_no_req", saw, 0);
`ifdef TDC_TIMEOUT_EN
        chk("tmo_idle", busy, 0);
        r.seq    = seq_e[7:0];
        r.flags  = 3'b001;
        r.coarse = 24'(MAXC);
        r.fine   = '0;
        sb.push_back(r);
        seq_e++;
        drain();
`else
        chk("no_tmo_busy", busy, 1);
`endif

        // reset while reading
        do_reset();
        meas(2, 1, 23'h99, 3'b000, 1, 0, 0);
        tos_mark = 1'b1;
        tick();
        tos_mark      = 1'b0;
        tdc_stop_next = 1'b1;
        tick();
        tdc_stop_next = 1'b0;
        chk("mid_req", tdc_rd_req, 1);
        tf_reset = 1'b1;
        #1;
        chk("async_req", tdc_rd_req, 0);
        chk("async_busy", busy, 0);
        chk("async_valid", res_valid, 0);
        tick();
        tf_reset = 1'b0;
        sb.delete();
        seq_e = 0;
        tick();
        chk("post_valid", res_valid, 0);
        meas(6, 2, 23'h4321, 3'b000, 1, 0, 0);
        drain();

        // measurement disabled
        meas_en  = 1'b0;
        tos_mark = 1'b1;
        #1;
        chk("dis_start", tdc_start_next, 0);
        tick();
        tos_mark = 1'b0;
        chk("dis_busy", busy, 0);
        repeat (5) tick();
        chk("dis_valid", res_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
